// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core: captures decoded fields, resolves
// operand forwarding from EX/MEM and MEM/WB, and stalls decode on load-use hazards.
module id_ex_stage #(
  parameter int          XLEN   = 32,
  parameter logic [4:0]  NOP_OP = 5'b00000
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [4:0]      id_alu_op,
  input  logic            id_src0_sel,
  input  logic            id_src1_sel,
  input  logic            id_we,
  input  logic            id_mem_rd,
  input  logic            flush,
  input  logic            exmem_we,
  input  logic [4:0]      exmem_rd,
  input  logic [XLEN-1:0] exmem_res,
  input  logic            memwb_we,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] memwb_res,
  output logic            ex_valid,
  output logic [XLEN-1:0] alu_src0,
  output logic [XLEN-1:0] alu_src1,
  output logic [4:0]      alu_op,
  output logic [4:0]      ex_rd,
  output logic            ex_we,
  output logic            ex_mem_rd,
  output logic [XLEN-1:0] ex_rs2_fwd
);

  logic            r_valid_p1;
  logic [XLEN-1:0] r_pc_p1;
  logic [XLEN-1:0] r_rs1_data_p1;
  logic [XLEN-1:0] r_rs2_data_p1;
  logic [XLEN-1:0] r_imm_p1;
  logic [4:0]      r_rs1_p1;
  logic [4:0]      r_rs2_p1;
  logic [4:0]      r_rd_p1;
  logic [4:0]      r_alu_op_p1;
  logic            r_src0_sel_p1;
  logic            r_src1_sel_p1;
  logic            r_we_p1;
  logic            r_mem_rd_p1;

  logic            w_load_use;
  logic [XLEN-1:0] w_fwd_rs1;
  logic [XLEN-1:0] w_fwd_rs2;

  // EX/MEM wins over MEM/WB because it carries the younger result; x0 is hardwired zero.
  function automatic logic [XLEN-1:0] f_fwd(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] reg_val,
    input logic            em_we,
    input logic [4:0]      em_rd,
    input logic [XLEN-1:0] em_res,
    input logic            mw_we,
    input logic [4:0]      mw_rd,
    input logic [XLEN-1:0] mw_res
  );
    if (em_we && (em_rd == rs) && (rs != 5'd0))
      return em_res;
    else if (mw_we && (mw_rd == rs) && (rs != 5'd0))
      return mw_res;
    else
      return reg_val;
  endfunction

  assign w_load_use = r_valid_p1 & r_mem_rd_p1 & (r_rd_p1 != 5'd0) & id_valid &
                      ((r_rd_p1 == id_rs1) | (r_rd_p1 == id_rs2));
  assign id_ready   = ~w_load_use;

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid_p1    <= 1'b0;
      r_pc_p1       <= '0;
      r_rs1_data_p1 <= '0;
      r_rs2_data_p1 <= '0;
      r_imm_p1      <= '0;
      r_rs1_p1      <= 5'd0;
      r_rs2_p1      <= 5'd0;
      r_rd_p1       <= 5'd0;
      r_alu_op_p1   <= NOP_OP;
      r_src0_sel_p1 <= 1'b0;
      r_src1_sel_p1 <= 1'b0;
      r_we_p1       <= 1'b0;
      r_mem_rd_p1   <= 1'b0;
    end else if (flush || w_load_use) begin
      r_valid_p1  <= 1'b0;
      r_we_p1     <= 1'b0;
      r_mem_rd_p1 <= 1'b0;
      r_alu_op_p1 <= NOP_OP;
    end else if (id_valid) begin
      r_valid_p1    <= 1'b1;
      r_pc_p1       <= id_pc;
      r_rs1_data_p1 <= id_rs1_data;
      r_rs2_data_p1 <= id_rs2_data;
      r_imm_p1      <= id_imm;
      r_rs1_p1      <= id_rs1;
      r_rs2_p1      <= id_rs2;
      r_rd_p1       <= id_rd;
      r_alu_op_p1   <= id_alu_op;
      r_src0_sel_p1 <= id_src0_sel;
      r_src1_sel_p1 <= id_src1_sel;
      r_we_p1       <= id_we;
      r_mem_rd_p1   <= id_mem_rd;
    end else begin
      r_valid_p1 <= 1'b0;
    end
  end

  assign w_fwd_rs1 = f_fwd(r_rs1_p1, r_rs1_data_p1, exmem_we, exmem_rd, exmem_res,
                           memwb_we, memwb_rd, memwb_res);
  assign w_fwd_rs2 = f_fwd(r_rs2_p1, r_rs2_data_p1, exmem_we, exmem_rd, exmem_res,
                           memwb_we, memwb_rd, memwb_res);

  assign ex_valid   = r_valid_p1;
  assign alu_src0   = r_src0_sel_p1 ? r_pc_p1  : w_fwd_rs1;
  assign alu_src1   = r_src1_sel_p1 ? r_imm_p1 : w_fwd_rs2;
  assign ex_rs2_fwd = w_fwd_rs2;
  assign alu_op     = r_valid_p1 ? r_alu_op_p1 : NOP_OP;
  assign ex_rd      = r_rd_p1;
  assign ex_we      = r_valid_p1 & r_we_p1;
  assign ex_mem_rd  = r_valid_p1 & r_mem_rd_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the EX stage contents.
module tb_id_ex_stage;

  logic        clk;
  logic        rstn;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd, id_alu_op;
  logic        id_src0_sel, id_src1_sel, id_we, id_mem_rd;
  logic        flush;
  logic        exmem_we, memwb_we;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_res, memwb_res;
  logic        ex_valid;
  logic [31:0] alu_src0, alu_src1, ex_rs2_fwd;
  logic [4:0]  alu_op, ex_rd;
  logic        ex_we, ex_mem_rd;

  int checks   = 0;
  int failures = 0;

  id_ex_stage #(.XLEN(32), .NOP_OP(5'b00000)) dut (
    .clk(clk), .rstn(rstn),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_src0_sel(id_src0_sel), .id_src1_sel(id_src1_sel), .id_we(id_we), .id_mem_rd(id_mem_rd),
    .flush(flush),
    .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_res(exmem_res),
    .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_res(memwb_res),
    .ex_valid(ex_valid), .alu_src0(alu_src0), .alu_src1(alu_src1), .alu_op(alu_op),
    .ex_rd(ex_rd), .ex_we(ex_we), .ex_mem_rd(ex_mem_rd), .ex_rs2_fwd(ex_rs2_fwd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of what instruction currently sits in EX.
  typedef struct {
    logic        valid;
    logic [31:0] pc, r1d, r2d, imm;
    logic [4:0]  rs1, rs2, rd, op;
    logic        s0, s1, we, mrd;
  } ex_t;

  ex_t m;

  function automatic ex_t ex_empty();
    ex_t e;
    e.valid = 0; e.pc = 0; e.r1d = 0; e.r2d = 0; e.imm = 0;
    e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.op = 0;
    e.s0 = 0; e.s1 = 0; e.we = 0; e.mrd = 0;
    return e;
  endfunction

  function automatic logic m_load_use();
    return m.valid && m.mrd && (m.rd != 0) && id_valid && ((m.rd == id_rs1) || (m.rd == id_rs2));
  endfunction

  function automatic logic [31:0] exp_fwd(input logic [4:0] rs, input logic [31:0] v);
    if (rs == 0) return v;
    if (exmem_we && exmem_rd == rs) return exmem_res;
    if (memwb_we && memwb_rd == rs) return memwb_res;
    return v;
  endfunction

  task automatic clr_inputs();
    id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_op = 0;
    id_src0_sel = 0; id_src1_sel = 0; id_we = 0; id_mem_rd = 0; flush = 0;
    exmem_we = 0; exmem_rd = 0; exmem_res = 0; memwb_we = 0; memwb_rd = 0; memwb_res = 0;
  endtask

  // Advance one clock, update the model from the inputs seen at the edge, return at negedge.
  task automatic tick();
    logic lu;
    @(posedge clk);
    if (!rstn) begin
      m = ex_empty();
    end else begin
      lu = m_load_use();
      if (flush || lu) m.valid = 0;
      else if (id_valid) begin
        m.valid = 1; m.pc = id_pc; m.r1d = id_rs1_data; m.r2d = id_rs2_data; m.imm = id_imm;
        m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd; m.op = id_alu_op;
        m.s0 = id_src0_sel; m.s1 = id_src1_sel; m.we = id_we; m.mrd = id_mem_rd;
      end else m.valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic load_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic [31:0] d1, input logic [31:0] d2, input logic [4:0] op,
                            input logic we, input logic mrd);
    clr_inputs();
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rs1_data = d1; id_rs2_data = d2;
    id_alu_op = op; id_we = we; id_mem_rd = mrd; id_pc = 32'h100; id_imm = 32'h40;
    tick();
    clr_inputs();
  endtask

  task automatic test_reset();
    clr_inputs();
    rstn = 1;
    load_instr(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 5'd7, 1'b1, 1'b0);
    id_valid = 1; id_we = 1; id_alu_op = 5'd9; flush = 0; exmem_we = 1; memwb_we = 1;
    #1 rstn = 0;
    m = ex_empty();
    #1;
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL reset_ex_valid got=%0b exp=0", ex_valid); end
    checks++; if (alu_op !== 5'b00000) begin failures++; $display("FAIL reset_alu_op got=%0h exp=0", alu_op); end
    checks++; if (ex_we !== 1'b0) begin failures++; $display("FAIL reset_ex_we got=%0b exp=0", ex_we); end
    tick();
    clr_inputs();
    rstn = 1;
    #1;
    checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL reset_id_ready got=%0b exp=1", id_ready); end
    checks++; if (alu_src0 !== 32'h0 || alu_src1 !== 32'h0) begin failures++;
      $display("FAIL reset_srcs got=%0h/%0h exp=0/0", alu_src0, alu_src1); end
    checks++; if (ex_rd !== 5'd0 || ex_mem_rd !== 1'b0) begin failures++;
      $display("FAIL reset_rd_mrd got=%0d/%0b exp=0/0", ex_rd, ex_mem_rd); end
  endtask

  task automatic test_plain_capture();
    load_instr(5'd1, 5'd2, 5'd5, 32'd5, 32'd7, 5'b00010, 1'b1, 1'b0);
    #1;
    checks++; if (alu_src0 !== 32'd5) begin failures++; $display("FAIL plain_src0 got=%0h exp=5", alu_src0); end
    checks++; if (alu_src1 !== 32'd7) begin failures++; $display("FAIL plain_src1 got=%0h exp=7", alu_src1); end
    checks++; if (alu_op !== 5'b00010) begin failures++; $display("FAIL plain_alu_op got=%0h exp=2", alu_op); end
    checks++; if (ex_valid !== 1'b1 || ex_we !== 1'b1) begin failures++;
      $display("FAIL plain_valid_we got=%0b/%0b exp=1/1", ex_valid, ex_we); end
  endtask

  task automatic test_fwd_priority();
    load_instr(5'd3, 5'd9, 5'd6, 32'h11, 32'h22, 5'd0, 1'b1, 1'b0);
    exmem_we = 1; exmem_rd = 3; exmem_res = 32'hAAAA;
    memwb_we = 1; memwb_rd = 3; memwb_res = 32'h5555;
    #1;
    checks++; if (alu_src0 !== 32'hAAAA) begin failures++; $display("FAIL fwd_exmem got=%0h exp=aaaa", alu_src0); end
    checks++; if (ex_rs2_fwd !== 32'h22) begin failures++; $display("FAIL fwd_rs2_nomatch got=%0h exp=22", ex_rs2_fwd); end
    exmem_we = 0;
    #1;
    checks++; if (alu_src0 !== 32'h5555) begin failures++; $display("FAIL fwd_memwb got=%0h exp=5555", alu_src0); end
    memwb_we = 0;
    #1;
    checks++; if (alu_src0 !== 32'h11) begin failures++; $display("FAIL fwd_none got=%0h exp=11", alu_src0); end
  endtask

  task automatic test_x0_guard();
    load_instr(5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
    exmem_we = 1; exmem_rd = 0; exmem_res = 32'h1234;
    memwb_we = 1; memwb_rd = 0; memwb_res = 32'h4321;
    #1;
    checks++; if (alu_src1 !== 32'h0) begin failures++; $display("FAIL x0_src1 got=%0h exp=0", alu_src1); end
    checks++; if (ex_rs2_fwd !== 32'h0 || alu_src0 !== 32'h0) begin failures++;
      $display("FAIL x0_rs2fwd_src0 got=%0h/%0h exp=0/0", ex_rs2_fwd, alu_src0); end
  endtask

  task automatic test_load_use();
    load_instr(5'd1, 5'd2, 5'd4, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1);
    id_valid = 1; id_rs1 = 4; id_rs2 = 8; id_rd = 6; id_rs1_data = 32'h99; id_alu_op = 5'd3; id_we = 1;
    #1;
    checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL lu_ready got=%0b exp=0", id_ready); end
    checks++; if (ex_mem_rd !== 1'b1) begin failures++; $display("FAIL lu_ex_mem_rd got=%0b exp=1", ex_mem_rd); end
    tick();
    #1;
    checks++; if (ex_valid !== 1'b0 || ex_we !== 1'b0 || ex_mem_rd !== 1'b0 || alu_op !== 5'd0) begin failures++;
      $display("FAIL lu_bubble got=v%0b we%0b mrd%0b op%0h exp=0/0/0/0", ex_valid, ex_we, ex_mem_rd, alu_op); end
    checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL lu_ready_after got=%0b exp=1", id_ready); end
    tick();
    id_valid = 0;
    #1;
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || alu_src0 !== 32'h99 || alu_op !== 5'd3) begin failures++;
      $display("FAIL lu_capture got=v%0b rd%0d src0=%0h op%0h exp=1/6/99/3", ex_valid, ex_rd, alu_src0, alu_op); end
  endtask

  task automatic test_flush_load_use();
    load_instr(5'd1, 5'd2, 5'd4, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1);
    id_valid = 1; id_rs1 = 9; id_rs2 = 4; id_rd = 7; id_we = 1; flush = 1;
    #1;
    checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL flu_ready got=%0b exp=0", id_ready); end
    tick();
    clr_inputs();
    #1;
    checks++; if (ex_valid !== 1'b0 || ex_we !== 1'b0) begin failures++;
      $display("FAIL flu_bubble got=v%0b we%0b exp=0/0", ex_valid, ex_we); end
    checks++; if (ex_rd !== 5'd4) begin failures++; $display("FAIL flu_no_capture got=%0d exp=4", ex_rd); end
  endtask

  task automatic test_random();
    logic stall;
    logic [31:0] e0, e1, e2;
    stall = 0;
    for (int i = 0; i < 400; i++) begin
      if (!stall) begin
        id_valid = ($urandom_range(0, 9) < 7);
        id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
        id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
        id_rd = 5'($urandom_range(0, 7)); id_alu_op = 5'($urandom);
        id_src0_sel = 1'($urandom); id_src1_sel = 1'($urandom);
        id_we = 1'($urandom); id_mem_rd = ($urandom_range(0, 9) < 3);
      end
      flush = ($urandom_range(0, 9) == 0);
      exmem_we = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7)); exmem_res = $urandom;
      memwb_we = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7)); memwb_res = $urandom;
      #1;
      e0 = m.s0 ? m.pc : exp_fwd(m.rs1, m.r1d);
      e2 = exp_fwd(m.rs2, m.r2d);
      e1 = m.s1 ? m.imm : e2;
      checks++; if (ex_valid !== m.valid) begin failures++; $display("FAIL rnd_valid i=%0d got=%0b exp=%0b", i, ex_valid, m.valid); end
      checks++; if (id_ready !== !m_load_use()) begin failures++; $display("FAIL rnd_ready i=%0d got=%0b exp=%0b", i, id_ready, !m_load_use()); end
      checks++; if (alu_op !== (m.valid ? m.op : 5'd0)) begin failures++; $display("FAIL rnd_alu_op i=%0d got=%0h", i, alu_op); end
      checks++; if (ex_we !== (m.valid & m.we) || ex_mem_rd !== (m.valid & m.mrd)) begin failures++;
        $display("FAIL rnd_we_mrd i=%0d got=%0b/%0b exp=%0b/%0b", i, ex_we, ex_mem_rd, m.valid & m.we, m.valid & m.mrd); end
      checks++; if (ex_rd !== m.rd) begin failures++; $display("FAIL rnd_rd i=%0d got=%0d exp=%0d", i, ex_rd, m.rd); end
      checks++; if (alu_src0 !== e0) begin failures++; $display("FAIL rnd_src0 i=%0d got=%0h exp=%0h", i, alu_src0, e0); end
      checks++; if (alu_src1 !== e1) begin failures++; $display("FAIL rnd_src1 i=%0d got=%0h exp=%0h", i, alu_src1, e1); end
      checks++; if (ex_rs2_fwd !== e2) begin failures++; $display("FAIL rnd_rs2fwd i=%0d got=%0h exp=%0h", i, ex_rs2_fwd, e2); end
      stall = id_valid && m_load_use() && !flush;
      tick();
    end
    clr_inputs();
  endtask

  initial begin
    m = ex_empty();
    clr_inputs();
    rstn = 0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_plain_capture();
    test_fwd_priority();
    test_x0_guard();
    test_load_use();
    test_flush_load_use();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
